// File: rtl/exec_stage_pkg.sv
// exec_stage_pkg: shared encodings and ALU operation decode for the RV64I execute stage
package exec_stage_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ZERO
    } alu_op_e;

    // I-type arithmetic never subtracts, so funct7_5 only selects sub for register operands
    function automatic alu_op_e funct_op(input logic [2:0] f3, input logic f7_5, input logic imm_src);
        case (f3)
            3'b000:  return (f7_5 && !imm_src) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/exec_stage_alu.sv
// alu_unit: combinational RV64I ALU; flags compare a against cmp_b (the forwarded rs2)
module alu_unit
    import exec_stage_pkg::*;
(
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] cmp_b,
    output logic [XLEN-1:0] result,
    output logic            lt,
    output logic            ltu,
    output logic            eq
);
    logic [5:0] sh;
    logic       slt_ab, sltu_ab;

    assign sh      = b[5:0];
    assign slt_ab  = $signed(a) < $signed(b);
    assign sltu_ab = a < b;
    assign lt      = $signed(a) < $signed(cmp_b);
    assign ltu     = a < cmp_b;
    assign eq      = a == cmp_b;

    always_comb begin
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << sh;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, slt_ab};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, sltu_ab};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> sh;
            ALU_SRA:  result = $signed(a) >>> sh;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// exec_stage: RV64I execute stage with forwarding, branch resolution, EX/MEM register and load-use detect
module exec_stage
    import exec_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            regWrite,
    input  logic            memToReg,
    input  logic            branch,
    input  logic            memRead,
    input  logic            memWrite,
    input  logic            aluSrc,
    input  logic [1:0]      aluOp,
    input  logic [XLEN-1:0] pcOut,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic [XLEN-1:0] imm,
    input  logic            funct7_5,
    input  logic [2:0]      funct3,
    input  logic [4:0]      wa,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic            wbRegWrite,
    input  logic [4:0]      wbWa,
    input  logic [XLEN-1:0] wbData,
    input  logic [4:0]      idRa1,
    input  logic [4:0]      idRa2,
    output logic            regWritereg,
    output logic            memToRegreg,
    output logic            memReadreg,
    output logic            memWritereg,
    output logic [XLEN-1:0] aluResultreg,
    output logic [XLEN-1:0] writeDatareg,
    output logic [4:0]      wareg,
    output logic [2:0]      funct3reg,
    output logic            pcSrcreg,
    output logic [XLEN-1:0] branchTargetreg,
    output logic            flush,
    output logic            stall
);
    logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;
    logic            lt, ltu, eq, cond;
    alu_op_e         op;

    assign flush = pcSrcreg;
    assign stall = memRead && wa != 5'd0 && (wa == idRa1 || wa == idRa2);

    // EX/MEM holds the younger result for a register, so it outranks MEM/WB
    assign fwd_a = (regWritereg && wareg != 5'd0 && wareg == ra1) ? aluResultreg :
                   (wbRegWrite && wbWa != 5'd0 && wbWa == ra1) ? wbData : rd1;
    assign fwd_b = (regWritereg && wareg != 5'd0 && wareg == ra2) ? aluResultreg :
                   (wbRegWrite && wbWa != 5'd0 && wbWa == ra2) ? wbData : rd2;
    assign op_b  = aluSrc ? imm : fwd_b;

    always_comb op = aluOp == ALUOP_ADD ? ALU_ADD :
                     aluOp == ALUOP_BR ? ALU_SUB :
                     aluOp == ALUOP_FUNCT ? funct_op(funct3, funct7_5, aluSrc) : ALU_ZERO;

    always_comb begin
        case (funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = !lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

    alu_unit u_alu (
        .op     (op),
        .a      (fwd_a),
        .b      (op_b),
        .cmp_b  (fwd_b),
        .result (alu_res),
        .lt     (lt),
        .ltu    (ltu),
        .eq     (eq)
    );

    // A taken branch turns whatever sits behind it in EX into a bubble
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            regWritereg     <= 1'b0;
            memToRegreg     <= 1'b0;
            memReadreg      <= 1'b0;
            memWritereg     <= 1'b0;
            aluResultreg    <= '0;
            writeDatareg    <= '0;
            wareg           <= 5'd0;
            funct3reg       <= 3'd0;
            pcSrcreg        <= 1'b0;
            branchTargetreg <= '0;
        end else begin
            regWritereg     <= regWrite;
            memToRegreg     <= memToReg;
            memReadreg      <= memRead;
            memWritereg     <= memWrite;
            aluResultreg    <= alu_res;
            writeDatareg    <= fwd_b;
            wareg           <= wa;
            funct3reg       <= funct3;
            pcSrcreg        <= branch && cond;
            branchTargetreg <= pcOut + imm;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: scoreboard bench for exec_stage (forwarding, ALU, branches, flush, stall, reset)
module tb_exec_stage;
    import exec_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        regWrite, memToReg, branch, memRead, memWrite, aluSrc, funct7_5;
    logic [1:0]  aluOp;
    logic [63:0] pcOut, rd1, rd2, imm, wbData;
    logic [2:0]  funct3;
    logic [4:0]  wa, ra1, ra2, wbWa, idRa1, idRa2;
    logic        wbRegWrite;
    logic        regWritereg, memToRegreg, memReadreg, memWritereg, pcSrcreg, flush, stall;
    logic [63:0] aluResultreg, writeDatareg, branchTargetreg;
    logic [4:0]  wareg;
    logic [2:0]  funct3reg;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [63:0] res;
        logic [63:0] wd;
        logic [4:0]  wa;
        logic [2:0]  f3;
        logic        pcsrc;
        logic [63:0] tgt;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
    } br_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

    br_t br_tbl [10] = '{
        '{3'b001, 64'd5, 64'd5}, '{3'b001, 64'd5, 64'd6}, '{3'b100, M1, 64'd1},
        '{3'b110, M1, 64'd1}, '{3'b101, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD},
        '{3'b111, 64'd0, 64'd1}, '{3'b010, 64'd4, 64'd4}, '{3'b011, 64'd4, 64'd4},
        '{3'b000, 64'd1, 64'd2}, '{3'b100, 64'd1, M1}
    };

    exec_stage dut (
        .clk(clk), .rst(rst), .regWrite(regWrite), .memToReg(memToReg), .branch(branch),
        .memRead(memRead), .memWrite(memWrite), .aluSrc(aluSrc), .aluOp(aluOp), .pcOut(pcOut),
        .rd1(rd1), .rd2(rd2), .imm(imm), .funct7_5(funct7_5), .funct3(funct3), .wa(wa),
        .ra1(ra1), .ra2(ra2), .wbRegWrite(wbRegWrite), .wbWa(wbWa), .wbData(wbData),
        .idRa1(idRa1), .idRa2(idRa2), .regWritereg(regWritereg), .memToRegreg(memToRegreg),
        .memReadreg(memReadreg), .memWritereg(memWritereg), .aluResultreg(aluResultreg),
        .writeDatareg(writeDatareg), .wareg(wareg), .funct3reg(funct3reg), .pcSrcreg(pcSrcreg),
        .branchTargetreg(branchTargetreg), .flush(flush), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs();
        exp_t o;
        o.ctrl  = {regWritereg, memToRegreg, memReadreg, memWritereg};
        o.res   = aluResultreg;
        o.wd    = writeDatareg;
        o.wa    = wareg;
        o.f3    = funct3reg;
        o.pcsrc = pcSrcreg;
        o.tgt   = branchTargetreg;
        return o;
    endfunction

    function automatic exp_t mk(input logic [3:0] c, input logic [63:0] r, input logic [63:0] w,
                                input logic [4:0] a, input logic [2:0] f, input logic p, input logic [63:0] t);
        exp_t o;
        o.ctrl = c; o.res = r; o.wd = w; o.wa = a; o.f3 = f; o.pcsrc = p; o.tgt = t;
        return o;
    endfunction

    function automatic logic br_model(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] alu_model(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                                               input logic src, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        if (op == 2'b00) r = a + b;
        else if (op == 2'b01) r = a - b;
        else if (op == 2'b11) r = 64'd0;
        else if (f3 == 3'b000) r = (f75 && !src) ? a - b : a + b;
        else if (f3 == 3'b001) r = a << b[5:0];
        else if (f3 == 3'b010) r = {63'd0, $signed(a) < $signed(b)};
        else if (f3 == 3'b011) r = {63'd0, a < b};
        else if (f3 == 3'b100) r = a ^ b;
        else if (f3 == 3'b101 && f75) r = $signed(a) >>> b[5:0];
        else if (f3 == 3'b101) r = a >> b[5:0];
        else if (f3 == 3'b110) r = a | b;
        else r = a & b;
        return r;
    endfunction

    // c = {regWrite, memToReg, branch, memRead, memWrite, aluSrc}
    task automatic set_ex(input logic [5:0] c, input logic [1:0] op, input logic [2:0] f3, input logic f75,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] im, input logic [63:0] pc,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w);
        {regWrite, memToReg, branch, memRead, memWrite, aluSrc} = c;
        aluOp = op; funct3 = f3; funct7_5 = f75; rd1 = a; rd2 = b; imm = im; pcOut = pc;
        ra1 = r1; ra2 = r2; wa = w;
    endtask

    task automatic issue(input exp_t x);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_ex(6'b111111, 2'b10, 3'b101, 1'b1, 64'd9, 64'd9, 64'd4, 64'h100, 5'd3, 5'd4, 5'd4);
        wbRegWrite = 1'b1; wbWa = 5'd3; wbData = 64'd77; idRa1 = 5'd4; idRa2 = 5'd0; rst = 1'b1;
        issue('0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL reset_regs: got %h want %h", obs(), e); end
        total++;
        if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b want 0", flush); end
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_follows: got %b want 1", stall); end
        rst = 1'b0; wbRegWrite = 1'b0; idRa1 = 5'd0;
    endtask

    task automatic test_forward();
        set_ex(6'b100001, 2'b00, 3'd0, 1'b0, 64'd7, 64'd0, 64'd3, 64'd0, 5'd1, 5'd2, 5'd5);
        issue(mk(4'b1000, 64'd10, 64'd0, 5'd5, 3'd0, 1'b0, 64'd3));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL fwd_setup: got %h want %h", obs(), e); end
        set_ex(6'b100000, 2'b10, 3'b000, 1'b0, 64'd99, 64'd3, 64'h55, 64'd0, 5'd5, 5'd6, 5'd8);
        issue(mk(4'b1000, 64'd13, 64'd3, 5'd8, 3'd0, 1'b0, 64'h55));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL fwd_exmem_a: got %h want %h", obs(), e); end
        set_ex(6'b100001, 2'b00, 3'd0, 1'b0, 64'd20, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd7);
        issue(mk(4'b1000, 64'd20, 64'd0, 5'd7, 3'd0, 1'b0, 64'd0));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL fwd_x7_setup: got %h want %h", obs(), e); end
        wbRegWrite = 1'b1; wbWa = 5'd7; wbData = 64'd30;
        set_ex(6'b100000, 2'b00, 3'd0, 1'b0, 64'd0, 64'd1, 64'd0, 64'd0, 5'd0, 5'd7, 5'd9);
        issue(mk(4'b1000, 64'd20, 64'd20, 5'd9, 3'd0, 1'b0, 64'd0));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL fwd_exmem_beats_wb: got %h want %h", obs(), e); end
        set_ex(6'b100001, 2'b00, 3'd0, 1'b0, 64'd7, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        issue(mk(4'b1000, 64'd7, 64'd0, 5'd0, 3'd0, 1'b0, 64'd0));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL fwd_x0_write: got %h want %h", obs(), e); end
        set_ex(6'b100000, 2'b00, 3'd0, 1'b0, 64'd5, 64'd1, 64'd0, 64'd0, 5'd0, 5'd7, 5'd10);
        issue(mk(4'b1000, 64'd35, 64'd30, 5'd10, 3'd0, 1'b0, 64'd0));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL fwd_wb_when_exmem_x0: got %h want %h", obs(), e); end
        set_ex(6'b100000, 2'b00, 3'd0, 1'b0, 64'd1, 64'd2, 64'd0, 64'd0, 5'd7, 5'd0, 5'd11);
        issue(mk(4'b1000, 64'd32, 64'd2, 5'd11, 3'd0, 1'b0, 64'd0));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL fwd_wb_a: got %h want %h", obs(), e); end
        wbRegWrite = 1'b0;
    endtask

    task automatic test_branch();
        logic t;
        set_ex(6'b001000, 2'b01, 3'b000, 1'b0, 64'd8, 64'd8, 64'h40, 64'h100, 5'd0, 5'd0, 5'd0);
        issue(mk(4'b0000, 64'd0, 64'd8, 5'd0, 3'd0, 1'b1, 64'h140));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL beq_taken: got %h want %h", obs(), e); end
        total++;
        if (flush !== 1'b1) begin bad++; $display("FAIL beq_flush: got %b want 1", flush); end
        set_ex(6'b110111, 2'b00, 3'd2, 1'b0, 64'd1, 64'd1, 64'd1, 64'd0, 5'd0, 5'd0, 5'd3);
        issue('0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL beq_bubble: got %h want %h", obs(), e); end
        total++;
        if (flush !== 1'b0) begin bad++; $display("FAIL beq_flush_one_cycle: got %b want 0", flush); end
        // branch comparison must see rs2 even with the immediate selected as ALU operand
        set_ex(6'b001001, 2'b01, 3'b000, 1'b0, 64'd8, 64'd8, 64'h40, 64'h0, 5'd0, 5'd0, 5'd0);
        issue(mk(4'b0000, 64'd8 - 64'h40, 64'd8, 5'd0, 3'd0, 1'b1, 64'h40));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL beq_uses_fwd_b: got %h want %h", obs(), e); end
        set_ex(6'b000000, 2'b00, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        issue('0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL beq_fwd_b_bubble: got %h want %h", obs(), e); end
        for (int i = 0; i < 10; i++) begin
            t = br_model(br_tbl[i].f3, br_tbl[i].a, br_tbl[i].b);
            set_ex(6'b001000, 2'b01, br_tbl[i].f3, 1'b0, br_tbl[i].a, br_tbl[i].b, 64'h40, 64'h100, 5'd0, 5'd0, 5'd0);
            issue(mk(4'b0000, br_tbl[i].a - br_tbl[i].b, br_tbl[i].b, 5'd0, br_tbl[i].f3, t, 64'h140));
            e = sb.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL branch%0d: got %h want %h", i, obs(), e); end
            total++;
            if (flush !== t) begin bad++; $display("FAIL branch%0d_flush: got %b want %b", i, flush, t); end
            if (t) begin
                set_ex(6'b100001, 2'b00, 3'd0, 1'b0, 64'd1, 64'd0, 64'd1, 64'd0, 5'd0, 5'd0, 5'd3);
                issue('0);
                e = sb.pop_front(); total++;
                if (obs() !== e) begin bad++; $display("FAIL branch%0d_bubble: got %h want %h", i, obs(), e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        set_ex(6'b001000, 2'b01, 3'b000, 1'b0, 64'd1, 64'd1, 64'h8, 64'h200, 5'd0, 5'd0, 5'd0);
        issue(mk(4'b0000, 64'd0, 64'd1, 5'd0, 3'd0, 1'b1, 64'h208));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL b2b_first: got %h want %h", obs(), e); end
        set_ex(6'b001000, 2'b01, 3'b001, 1'b0, 64'd1, 64'd2, 64'h8, 64'h204, 5'd0, 5'd0, 5'd0);
        issue('0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL b2b_second_squashed: got %h want %h", obs(), e); end
        total++;
        if (flush !== 1'b0) begin bad++; $display("FAIL b2b_no_second_flush: got %b want 0", flush); end
        set_ex(6'b001000, 2'b01, 3'b000, 1'b0, 64'd1, 64'd1, 64'h8, 64'h300, 5'd0, 5'd0, 5'd0);
        issue(mk(4'b0000, 64'd0, 64'd1, 5'd0, 3'd0, 1'b1, 64'h308));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL rst_mid_setup: got %h want %h", obs(), e); end
        rst = 1'b1;
        set_ex(6'b111001, 2'b00, 3'd0, 1'b0, 64'd4, 64'd0, 64'd4, 64'd0, 5'd0, 5'd0, 5'd6);
        issue('0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL rst_mid_regs: got %h want %h", obs(), e); end
        total++;
        if (flush !== 1'b0) begin bad++; $display("FAIL rst_mid_flush: got %b want 0", flush); end
        rst = 1'b0;
    endtask

    task automatic test_stall();
        logic [15:0] tbl [5] = '{16'b1_00100_00000_00100, 16'b1_00000_00000_00000,
                                 16'b1_00100_00100_00000, 16'b0_00100_00100_00100,
                                 16'b1_00100_00011_00101};
        logic exp_s [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            memRead = tbl[i][15]; wa = tbl[i][14:10]; idRa1 = tbl[i][9:5]; idRa2 = tbl[i][4:0];
            #1;
            total++;
            if (stall !== exp_s[i]) begin bad++; $display("FAIL stall%0d: got %b want %b", i, stall, exp_s[i]); end
        end
        memRead = 1'b0; idRa1 = 5'd0; idRa2 = 5'd0;
    endtask

    task automatic test_alu();
        logic [1:0] op;
        logic [2:0] f3;
        logic f75, src;
        logic [3:0] c;
        logic [63:0] a, b, im;
        set_ex(6'b000001, 2'b10, 3'b101, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 64'd68, 64'd0, 5'd0, 5'd0, 5'd1);
        issue(mk(4'b0000, 64'hF800_0000_0000_0000, 64'd0, 5'd1, 3'd5, 1'b0, 64'd68));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL alu_sra: got %h want %h", obs(), e); end
        set_ex(6'b100000, 2'b10, 3'b011, 1'b0, M1, 64'd1, 64'd0, 64'd0, 5'd0, 5'd0, 5'd2);
        issue(mk(4'b1000, 64'd0, 64'd1, 5'd2, 3'd3, 1'b0, 64'd0));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL alu_sltu: got %h want %h", obs(), e); end
        set_ex(6'b100000, 2'b10, 3'b010, 1'b0, M1, 64'd1, 64'd0, 64'd0, 5'd0, 5'd0, 5'd2);
        issue(mk(4'b1000, 64'd1, 64'd1, 5'd2, 3'd2, 1'b0, 64'd0));
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL alu_slt: got %h want %h", obs(), e); end
        for (int i = 0; i < 32; i++) begin
            op = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
            f75 = 1'($urandom_range(0, 1)); src = 1'($urandom_range(0, 1)); c = 4'($urandom_range(0, 15));
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; im = {$urandom, $urandom};
            set_ex({c[3:2], 1'b0, c[1:0], src}, op, f3, f75, a, b, im, 64'h1000, 5'd0, 5'd0, 5'(i));
            issue(mk(c, alu_model(op, f3, f75, src, a, src ? im : b), b, 5'(i), f3, 1'b0, 64'h1000 + im));
            e = sb.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL alu_rand%0d: got %h want %h", i, obs(), e); end
        end
        memRead = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wbRegWrite = 1'b0; wbWa = 5'd0; wbData = 64'd0; idRa1 = 5'd0; idRa2 = 5'd0;
        set_ex(6'b000000, 2'b00, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_forward();
        test_branch();
        test_back_to_back();
        test_stall();
        test_alu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
